// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the decode-to-execute stage: ALU opcodes,
// register index width and the operand forward-select encoding.
package id_ex_stage_pkg;

    localparam int REG_ADDR_W = 5;

    // ALU opcodes presented on alu_controls
    localparam logic [5:0] ALU_ADD   = 6'b000000;
    localparam logic [5:0] ALU_SUB   = 6'b000001;
    localparam logic [5:0] ALU_AND   = 6'b000010;
    localparam logic [5:0] ALU_OR    = 6'b000011;
    localparam logic [5:0] ALU_XOR   = 6'b000100;
    localparam logic [5:0] ALU_SLL   = 6'b000101;
    localparam logic [5:0] ALU_SRL   = 6'b000110;
    localparam logic [5:0] ALU_SRA   = 6'b000111;
    localparam logic [5:0] ALU_SLT   = 6'b001000;
    localparam logic [5:0] ALU_SLTU  = 6'b001001;
    localparam logic [5:0] ALU_EQ    = 6'b001010;
    localparam logic [5:0] ALU_NE    = 6'b001011;
    localparam logic [5:0] ALU_PASSA = 6'b001100;
    localparam logic [5:0] ALU_PASSB = 6'b001101;

    // Where a source operand comes from this cycle
    typedef enum logic [1:0] {
        FWD_REG,
        FWD_MEM,
        FWD_WB
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// Per-operand forwarding: compares one registered source index against the
// MEM and WB producers and picks the youngest matching value. x0 never forwards.
module id_ex_stage_fwd_sel
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 5
) (
    input  logic [ADDR_W-1:0]     rs_addr,
    input  logic [DATA_WIDTH-1:0] reg_data,
    input  logic                  m_valid,
    input  logic                  m_reg_write,
    input  logic [ADDR_W-1:0]     m_rd_addr,
    input  logic [DATA_WIDTH-1:0] m_fwd_data,
    input  logic                  w_valid,
    input  logic                  w_reg_write,
    input  logic [ADDR_W-1:0]     w_rd_addr,
    input  logic [DATA_WIDTH-1:0] w_result,
    output logic [DATA_WIDTH-1:0] fwd_data
);

    fwd_sel_e sel;

    // Select the source: MEM beats WB, both beat the register-file copy
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
        sel = FWD_REG;
        if (m_valid && m_reg_write && (m_rd_addr != '0) && (m_rd_addr == rs_addr)) begin
            sel = FWD_MEM;
        end else if (w_valid && w_reg_write && (w_rd_addr != '0) && (w_rd_addr == rs_addr)) begin
            sel = FWD_WB;
        end
    end

    // Operand mux driven by the select
    always_comb begin
        case (sel)
            FWD_MEM: fwd_data = m_fwd_data;
            FWD_WB:  fwd_data = w_result;
            default: fwd_data = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with RAW forwarding, load-use bubble
// insertion and ALU operand selection from registered state.
module id_ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = id_ex_stage_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_valid,
    input  logic [DATA_WIDTH-1:0] d_pc,
    input  logic [DATA_WIDTH-1:0] d_imm,
    input  logic [DATA_WIDTH-1:0] d_rs1_data,
    input  logic [DATA_WIDTH-1:0] d_rs2_data,
    input  logic [REG_ADDR_W-1:0] d_rs1_addr,
    input  logic [REG_ADDR_W-1:0] d_rs2_addr,
    input  logic [REG_ADDR_W-1:0] d_rd_addr,
    input  logic [5:0]            d_alu_controls,
    input  logic [2:0]            d_funct3,
    input  logic                  d_src_a_pc,
    input  logic                  d_src_b_imm,
    input  logic                  d_reg_write,
    input  logic                  d_mem_read,
    input  logic                  d_mem_write,
    input  logic                  d_branch,
    input  logic                  d_jump,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  m_valid,
    input  logic                  m_reg_write,
    input  logic [REG_ADDR_W-1:0] m_rd_addr,
    input  logic [DATA_WIDTH-1:0] m_fwd_data,
    input  logic                  w_valid,
    input  logic                  w_reg_write,
    input  logic [REG_ADDR_W-1:0] w_rd_addr,
    input  logic [DATA_WIDTH-1:0] w_result,
    output logic                  load_use_hazard,
    output logic                  e_valid,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [5:0]            alu_controls,
    output logic                  funct3b0,
    output logic [DATA_WIDTH-1:0] e_store_data,
    output logic [DATA_WIDTH-1:0] e_pc,
    output logic [DATA_WIDTH-1:0] e_imm,
    output logic [REG_ADDR_W-1:0] e_rd_addr,
    output logic                  e_reg_write,
    output logic                  e_mem_read,
    output logic                  e_mem_write,
    output logic                  e_branch,
    output logic                  e_jump
);

    import id_ex_stage_pkg::*;

    // Everything held between decode and execute; all-zero is a bubble
    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] imm;
        logic [DATA_WIDTH-1:0] rs1_data;
        logic [DATA_WIDTH-1:0] rs2_data;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [5:0]            alu_controls;
        logic                  funct3b0;
        logic                  src_a_pc;
        logic                  src_b_imm;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
    } ex_reg_t;

    ex_reg_t               ex_q;
    ex_reg_t               dec_fields;
    logic [DATA_WIDTH-1:0] fwd_rs1;
    logic [DATA_WIDTH-1:0] fwd_rs2;
    logic                  unused_funct3_hi;

    // Only funct3[0] travels on to the ALU
    assign unused_funct3_hi = ^d_funct3[2:1];

    // Gather the decode slot into the stage record
    always_comb begin
        dec_fields              = '0;
        dec_fields.valid        = d_valid;
        dec_fields.pc           = d_pc;
        dec_fields.imm          = d_imm;
        dec_fields.rs1_data     = d_rs1_data;
        dec_fields.rs2_data     = d_rs2_data;
        dec_fields.rs1_addr     = d_rs1_addr;
        dec_fields.rs2_addr     = d_rs2_addr;
        dec_fields.rd_addr      = d_rd_addr;
        dec_fields.alu_controls = d_alu_controls;
        dec_fields.funct3b0     = d_funct3[0];
        dec_fields.src_a_pc     = d_src_a_pc;
        dec_fields.src_b_imm    = d_src_b_imm;
        dec_fields.reg_write    = d_reg_write;
        dec_fields.mem_read     = d_mem_read;
        dec_fields.mem_write    = d_mem_write;
        dec_fields.branch       = d_branch;
        dec_fields.jump         = d_jump;
    end

    // A load in execute feeds the instruction in decode: hold decode one cycle.
    // A flush kills both, so it also suppresses the hazard.
    assign load_use_hazard = !flush && ex_q.valid && ex_q.mem_read &&
                             (ex_q.rd_addr != '0) && d_valid &&
                             ((d_rs1_addr == ex_q.rd_addr) || (d_rs2_addr == ex_q.rd_addr));

    id_ex_stage_fwd_sel #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
        .rs_addr    (ex_q.rs1_addr),
        .reg_data   (ex_q.rs1_data),
        .m_valid    (m_valid),
        .m_reg_write(m_reg_write),
        .m_rd_addr  (m_rd_addr),
        .m_fwd_data (m_fwd_data),
        .w_valid    (w_valid),
        .w_reg_write(w_reg_write),
        .w_rd_addr  (w_rd_addr),
        .w_result   (w_result),
        .fwd_data   (fwd_rs1)
    );

    id_ex_stage_fwd_sel #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
        .rs_addr    (ex_q.rs2_addr),
        .reg_data   (ex_q.rs2_data),
        .m_valid    (m_valid),
        .m_reg_write(m_reg_write),
        .m_rd_addr  (m_rd_addr),
        .m_fwd_data (m_fwd_data),
        .w_valid    (w_valid),
        .w_reg_write(w_reg_write),
        .w_rd_addr  (w_rd_addr),
        .w_result   (w_result),
        .fwd_data   (fwd_rs2)
    );

    // Stage register: reset > flush > stall (refresh operands) > load-use bubble > capture
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (rst) begin
            ex_q <= '0;
        end else if (flush) begin
            ex_q <= '0;
        end else if (stall) begin
            // Keep absorbing producers that retire while we wait
            ex_q.rs1_data <= fwd_rs1;
            ex_q.rs2_data <= fwd_rs2;
        end else if (load_use_hazard) begin
            ex_q <= '0;
        end else begin
            ex_q <= dec_fields;
        end
    end

    assign alu_a        = ex_q.src_a_pc  ? ex_q.pc  : fwd_rs1;
    assign alu_b        = ex_q.src_b_imm ? ex_q.imm : fwd_rs2;
    assign e_store_data = fwd_rs2;

    assign e_valid      = ex_q.valid;
    assign alu_controls = ex_q.alu_controls;
    assign funct3b0     = ex_q.funct3b0;
    assign e_pc         = ex_q.pc;
    assign e_imm        = ex_q.imm;
    assign e_rd_addr    = ex_q.rd_addr;
    assign e_reg_write  = ex_q.reg_write;
    assign e_mem_read   = ex_q.mem_read;
    assign e_mem_write  = ex_q.mem_write;
    assign e_branch     = ex_q.branch;
    assign e_jump       = ex_q.jump;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/forwarding scenarios
// followed by randomized traffic against a behavioural stage model.
module tb_id_ex_stage;

    import id_ex_stage_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          d_valid;
    logic [DW-1:0] d_pc, d_imm, d_rs1_data, d_rs2_data;
    logic [AW-1:0] d_rs1_addr, d_rs2_addr, d_rd_addr;
    logic [5:0]    d_alu_controls;
    logic [2:0]    d_funct3;
    logic          d_src_a_pc, d_src_b_imm;
    logic          d_reg_write, d_mem_read, d_mem_write, d_branch, d_jump;
    logic          stall, flush;
    logic          m_valid, m_reg_write;
    logic [AW-1:0] m_rd_addr;
    logic [DW-1:0] m_fwd_data;
    logic          w_valid, w_reg_write;
    logic [AW-1:0] w_rd_addr;
    logic [DW-1:0] w_result;
    logic          load_use_hazard, e_valid;
    logic [DW-1:0] alu_a, alu_b, e_store_data, e_pc, e_imm;
    logic [5:0]    alu_controls;
    logic          funct3b0;
    logic [AW-1:0] e_rd_addr;
    logic          e_reg_write, e_mem_read, e_mem_write, e_branch, e_jump;

    id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .d_valid(d_valid),
        .d_pc(d_pc), .d_imm(d_imm), .d_rs1_data(d_rs1_data), .d_rs2_data(d_rs2_data),
        .d_rs1_addr(d_rs1_addr), .d_rs2_addr(d_rs2_addr), .d_rd_addr(d_rd_addr),
        .d_alu_controls(d_alu_controls), .d_funct3(d_funct3),
        .d_src_a_pc(d_src_a_pc), .d_src_b_imm(d_src_b_imm),
        .d_reg_write(d_reg_write), .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
        .d_branch(d_branch), .d_jump(d_jump),
        .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_reg_write(m_reg_write), .m_rd_addr(m_rd_addr), .m_fwd_data(m_fwd_data),
        .w_valid(w_valid), .w_reg_write(w_reg_write), .w_rd_addr(w_rd_addr), .w_result(w_result),
        .load_use_hazard(load_use_hazard), .e_valid(e_valid),
        .alu_a(alu_a), .alu_b(alu_b), .alu_controls(alu_controls), .funct3b0(funct3b0),
        .e_store_data(e_store_data), .e_pc(e_pc), .e_imm(e_imm), .e_rd_addr(e_rd_addr),
        .e_reg_write(e_reg_write), .e_mem_read(e_mem_read), .e_mem_write(e_mem_write),
        .e_branch(e_branch), .e_jump(e_jump)
    );

    always #5 clk = ~clk;

    // Behavioural picture of the instruction sitting in execute
    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc, imm, rs1_data, rs2_data;
        logic [AW-1:0] rs1, rs2, rd;
        logic [5:0]    op;
        logic          f0, sa, sb, rw, mr, mw, br, jp;
    } ex_t;

    ex_t mdl;
    int  total = 0;
    int  bad   = 0;

    // Youngest live producer of a nonzero register supplies its value
    function automatic logic [DW-1:0] model_fwd(input logic [AW-1:0] a, input logic [DW-1:0] r);
        if (a == 0) return r;
        if (m_valid && m_reg_write && m_rd_addr == a) return m_fwd_data;
        if (w_valid && w_reg_write && w_rd_addr == a) return w_result;
        return r;
    endfunction

    function automatic logic model_hazard();
        if (flush || !mdl.valid || !mdl.mr || mdl.rd == 0 || !d_valid) return 1'b0;
        return (d_rs1_addr == mdl.rd) || (d_rs2_addr == mdl.rd);
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model in the current cycle
    task automatic check_model(input string tag);
        logic [DW-1:0] ea, eb;
        ea = mdl.sa ? mdl.pc  : model_fwd(mdl.rs1, mdl.rs1_data);
        eb = mdl.sb ? mdl.imm : model_fwd(mdl.rs2, mdl.rs2_data);
        check({tag, "/hazard"}, 32'(load_use_hazard), 32'(model_hazard()));
        check({tag, "/e_valid"}, 32'(e_valid), 32'(mdl.valid));
        check({tag, "/alu_a"}, alu_a, ea);
        check({tag, "/alu_b"}, alu_b, eb);
        check({tag, "/store"}, e_store_data, model_fwd(mdl.rs2, mdl.rs2_data));
        check({tag, "/ctl_op"}, 32'({alu_controls, funct3b0}), 32'({mdl.op, mdl.f0}));
        check({tag, "/e_pc"}, e_pc, mdl.pc);
        check({tag, "/e_imm"}, e_imm, mdl.imm);
        check({tag, "/e_rd"}, 32'(e_rd_addr), 32'(mdl.rd));
        check({tag, "/ctl"}, 32'({e_reg_write, e_mem_read, e_mem_write, e_branch, e_jump}),
              32'({mdl.rw, mdl.mr, mdl.mw, mdl.br, mdl.jp}));
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge
    task automatic tick();
        ex_t nxt;
        nxt = mdl;
        if (rst || flush) begin
            nxt = '0;
        end else if (stall) begin
            nxt.rs1_data = model_fwd(mdl.rs1, mdl.rs1_data);
            nxt.rs2_data = model_fwd(mdl.rs2, mdl.rs2_data);
        end else if (model_hazard()) begin
            nxt = '0;
        end else begin
            nxt.valid = d_valid;     nxt.pc = d_pc;             nxt.imm = d_imm;
            nxt.rs1_data = d_rs1_data; nxt.rs2_data = d_rs2_data;
            nxt.rs1 = d_rs1_addr;    nxt.rs2 = d_rs2_addr;      nxt.rd = d_rd_addr;
            nxt.op = d_alu_controls; nxt.f0 = d_funct3[0];
            nxt.sa = d_src_a_pc;     nxt.sb = d_src_b_imm;
            nxt.rw = d_reg_write;    nxt.mr = d_mem_read;       nxt.mw = d_mem_write;
            nxt.br = d_branch;       nxt.jp = d_jump;
        end
        @(posedge clk);
        mdl = nxt;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rst = 1'b0; d_valid = 1'b0; d_pc = '0; d_imm = '0; d_rs1_data = '0; d_rs2_data = '0;
        d_rs1_addr = '0; d_rs2_addr = '0; d_rd_addr = '0; d_alu_controls = '0; d_funct3 = '0;
        d_src_a_pc = 1'b0; d_src_b_imm = 1'b0; d_reg_write = 1'b0; d_mem_read = 1'b0;
        d_mem_write = 1'b0; d_branch = 1'b0; d_jump = 1'b0; stall = 1'b0; flush = 1'b0;
        m_valid = 1'b0; m_reg_write = 1'b0; m_rd_addr = '0; m_fwd_data = '0;
        w_valid = 1'b0; w_reg_write = 1'b0; w_rd_addr = '0; w_result = '0;
    endtask

    task automatic decode(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                          input logic [DW-1:0] r1d, input logic [DW-1:0] r2d, input logic mr);
        d_valid = 1'b1; d_rs1_addr = rs1; d_rs2_addr = rs2; d_rd_addr = rd;
        d_rs1_data = r1d; d_rs2_data = r2d; d_pc = $urandom; d_imm = $urandom;
        d_alu_controls = ALU_ADD; d_funct3 = 3'b001; d_src_a_pc = 1'b0; d_src_b_imm = 1'b0;
        d_reg_write = 1'b1; d_mem_read = mr; d_mem_write = 1'b0; d_branch = 1'b0; d_jump = 1'b0;
    endtask

    initial begin
        mdl = '0;
        clear_inputs();

        // Reset held two cycles with a live decode slot
        rst = 1'b1;
        decode(5'd3, 5'd4, 5'd6, 32'hdead, 32'hbeef, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset/e_valid", 32'(e_valid), 32'd0);
        check("reset/alu_a", alu_a, 32'd0);
        check("reset/alu_b", alu_b, 32'd0);
        check("reset/alu_controls", 32'(alu_controls), 32'd0);
        check_model("reset");

        // MEM beats WB; x0 on MEM lets WB through
        decode(5'd5, 5'd6, 5'd10, 32'h11, 32'h22, 1'b0);
        tick();
        d_valid = 1'b0;
        m_valid = 1'b1; m_reg_write = 1'b1; m_rd_addr = 5'd5; m_fwd_data = 32'hAA;
        w_valid = 1'b1; w_reg_write = 1'b1; w_rd_addr = 5'd5; w_result = 32'hBB;
        #1;
        check("memfwd/alu_a", alu_a, 32'hAA);
        check_model("memfwd");
        m_rd_addr = 5'd0;
        #1;
        check("wbfwd/alu_a", alu_b == 32'h22 ? alu_a : 32'hx, 32'hBB);
        check_model("wbfwd");

        // x0 is never forwarded
        clear_inputs();
        decode(5'd1, 5'd0, 5'd11, 32'h33, 32'h0, 1'b0);
        tick();
        d_valid = 1'b0;
        m_valid = 1'b1; m_reg_write = 1'b1; m_rd_addr = 5'd0; m_fwd_data = 32'hFF;
        #1;
        check("x0/alu_b", alu_b, 32'h0);
        check("x0/store", e_store_data, 32'h0);
        check_model("x0");

        // Load followed by a consumer of its destination
        clear_inputs();
        decode(5'd2, 5'd3, 5'd7, 32'h44, 32'h55, 1'b1);
        tick();
        decode(5'd1, 5'd7, 5'd12, 32'h66, 32'h77, 1'b0);
        #1;
        check("lu/hazard", 32'(load_use_hazard), 32'd1);
        check_model("lu_detect");
        tick();
        check("lu/bubble_valid", 32'(e_valid), 32'd0);
        check("lu/bubble_ctl", 32'({e_reg_write, e_mem_read, e_mem_write, e_branch, e_jump}), 32'd0);
        check_model("lu_bubble");
        tick();
        check("lu/capture_valid", 32'(e_valid), 32'd1);
        check("lu/capture_rd", 32'(e_rd_addr), 32'd12);
        check_model("lu_capture");

        // Stall: a WB producer seen once during the stall must stick
        clear_inputs();
        decode(5'd9, 5'd4, 5'd13, 32'h50, 32'h60, 1'b0);
        tick();
        d_valid = 1'b0;
        stall = 1'b1;
        w_valid = 1'b1; w_reg_write = 1'b1; w_rd_addr = 5'd9; w_result = 32'h1234;
        #1;
        check("stall/fwd_now", alu_a, 32'h1234);
        tick();
        w_valid = 1'b0; w_reg_write = 1'b0; w_rd_addr = 5'd0; w_result = 32'h0;
        #1;
        check("stall/refreshed", alu_a, 32'h1234);
        tick();
        tick();
        stall = 1'b0;
        #1;
        check("stall/after", alu_a, 32'h1234);
        check_model("stall");

        // Flush and stall together over a would-be load-use
        clear_inputs();
        decode(5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 1'b1);
        tick();
        decode(5'd3, 5'd5, 5'd14, 32'h3, 32'h4, 1'b0);
        flush = 1'b1;
        stall = 1'b1;
        #1;
        check("flush/hazard", 32'(load_use_hazard), 32'd0);
        check("flush/before_valid", 32'(e_valid), 32'd1);
        tick();
        check("flush/e_valid", 32'(e_valid), 32'd0);
        check_model("flush");
        flush = 1'b0;
        stall = 1'b0;

        // Randomized traffic with a small register window to provoke hazards
        repeat (400) begin
            rst            = ($urandom_range(0, 49) == 0);
            flush          = ($urandom_range(0, 9) == 0);
            stall          = ($urandom_range(0, 4) == 0);
            d_valid        = ($urandom_range(0, 3) != 0);
            d_pc           = $urandom;
            d_imm          = $urandom;
            d_rs1_data     = $urandom;
            d_rs2_data     = $urandom;
            d_rs1_addr     = 5'($urandom_range(0, 3));
            d_rs2_addr     = 5'($urandom_range(0, 3));
            d_rd_addr      = 5'($urandom_range(0, 3));
            d_alu_controls = 6'($urandom_range(0, 13));
            d_funct3       = 3'($urandom_range(0, 7));
            d_src_a_pc     = 1'($urandom_range(0, 1));
            d_src_b_imm    = 1'($urandom_range(0, 1));
            d_reg_write    = 1'($urandom_range(0, 1));
            d_mem_read     = ($urandom_range(0, 2) == 0);
            d_mem_write    = 1'($urandom_range(0, 1));
            d_branch       = 1'($urandom_range(0, 1));
            d_jump         = 1'($urandom_range(0, 1));
            m_valid        = 1'($urandom_range(0, 1));
            m_reg_write    = 1'($urandom_range(0, 1));
            m_rd_addr      = 5'($urandom_range(0, 3));
            m_fwd_data     = $urandom;
            w_valid        = 1'($urandom_range(0, 1));
            w_reg_write    = 1'($urandom_range(0, 1));
            w_rd_addr      = 5'($urandom_range(0, 3));
            w_result       = $urandom;
            #1;
            check_model("rand");
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
